// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and result bus of the shift-add multiplier.
interface shift_add_multiplier_if #(
    parameter int unsigned WIDTH = 10
);
    logic               start;
    logic [WIDTH-1:0]   in_A;
    logic [WIDTH-1:0]   in_B;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   product_out;
    logic [2*WIDTH-1:0] full_product;
    logic               ovf;
    logic               zero;

    modport master (
        output start, in_A, in_B,
        input  busy, done, product_out, full_product, ovf, zero
    );

    modport slave (
        input  start, in_A, in_B,
        output busy, done, product_out, full_product, ovf, zero
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned fixed-point multiplier (QWIDTH-FRAC.FRAC operands).
// One shift-add iteration per clock over an {acc, q} shift register;
// a zero operand skips the iterations entirely.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned FRAC  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    shift_add_multiplier_if.slave       bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   q_q;
    logic [CntW-1:0]    count_q;
    logic [2*WIDTH-1:0] full_q;
    logic               zero_q;
    logic [WIDTH:0]     sum;
    logic               load_zero;
    logic               last_iter;

    // Datapath combinational terms: conditional add and loop/zero decode
    always_comb begin
        sum       = q_q[0] ? (acc_q + {1'b0, a_q}) : acc_q;
        load_zero = (bus.in_A == '0) || (bus.in_B == '0);
        last_iter = (count_q == CntW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Moore outputs decode from state only
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StLoad;
            end
            StLoad: begin
                bus.busy = 1'b1;
                state_d  = load_zero ? StDone : StCalc;
            end
            StCalc: begin
                bus.busy = 1'b1;
                if (last_iter) state_d = StDone;
            end
            StDone: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand capture, shift-add iterations and result latching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            count_q <= '0;
            full_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    a_q     <= bus.in_A;
                    q_q     <= bus.in_B;
                    acc_q   <= '0;
                    count_q <= '0;
                    zero_q  <= load_zero;
                    // Clearing here doubles as the zero fast-path result
                    full_q  <= '0;
                end
                StCalc: begin
                    acc_q   <= {1'b0, sum[WIDTH:1]};
                    q_q     <= {sum[0], q_q[WIDTH-1:1]};
                    count_q <= count_q + CntW'(1);
                    // {acc[WIDTH-1:0], q} after the shift equals {sum, q[WIDTH-1:1]}
                    if (last_iter) full_q <= {sum, q_q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    // Truncated result and overflow flag are slices of the held full product
    always_comb begin
        bus.full_product = full_q;
        bus.product_out  = full_q[WIDTH+FRAC-1:FRAC];
        bus.ovf          = |full_q[2*WIDTH-1:WIDTH+FRAC];
        bus.zero         = zero_q;
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised self-checking bench for shift_add_multiplier against an
// arithmetic reference (plain integer multiply and slicing).
module tb_shift_add_multiplier;
    localparam int unsigned W = 10;
    localparam int unsigned F = 4;
    localparam int Lim = 60;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W), .FRAC(F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // After the LOAD edge: wait for done, check latency, results and the one-cycle pulse.
    task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        longint unsigned prod;
        int edges;
        int exp_lat;
        bit is_zero;
        prod    = longint'(a) * longint'(b);
        is_zero = (a == 0) || (b == 0);
        exp_lat = is_zero ? 1 : W + 1;
        edges   = 1;
        while (!bus.done && edges < Lim) begin
            if (scramble) begin
                bus.in_A = W'($urandom);
                bus.in_B = W'($urandom);
            end
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq("latency", 64'(edges), 64'(exp_lat));
        check_eq("busy_at_done", 64'(bus.busy), 64'd1);
        check_eq("full_product", 64'(bus.full_product), prod);
        check_eq("product_out", 64'(bus.product_out), (prod >> F) & ((64'd1 << W) - 1));
        check_eq("ovf", 64'(bus.ovf), 64'((prod >> (W + F)) != 0));
        check_eq("zero", 64'(bus.zero), 64'(is_zero));
        @(posedge clk);
        #1;
        check_eq("done_pulse_end", 64'(bus.done), 64'd0);
        check_eq("idle_busy", 64'(bus.busy), 64'd0);
        check_eq("hold_full", 64'(bus.full_product), prod);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_A  = a;
        bus.in_B  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        finish_op(a, b, 1'b1);
    endtask

    initial begin
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.in_A  = '0;
        bus.in_B  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_full", 64'(bus.full_product), 64'd0);
        check_eq("rst_prod", 64'(bus.product_out), 64'd0);
        check_eq("rst_ovf", 64'(bus.ovf), 64'd0);
        check_eq("rst_zero", 64'(bus.zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known operand cases
        run_op(10'd40, 10'd64);
        run_op(10'd1023, 10'd32);
        run_op(10'd1023, 10'd1023);
        run_op(10'd1, 10'd1);
        run_op(10'd0, 10'd500);
        run_op(10'd77, 10'd0);

        // Reset mid-CALC, checked before the next edge
        bus.in_A  = 10'd40;
        bus.in_B  = 10'd64;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(bus.busy), 64'd0);
        check_eq("midrst_done", 64'(bus.done), 64'd0);
        check_eq("midrst_full", 64'(bus.full_product), 64'd0);
        check_eq("midrst_prod", 64'(bus.product_out), 64'd0);
        check_eq("midrst_ovf", 64'(bus.ovf), 64'd0);
        check_eq("midrst_zero", 64'(bus.zero), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(10'd40, 10'd64);

        // Held start with operands toggling during CALC
        bus.in_A  = 10'd555;
        bus.in_B  = 10'd321;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        finish_op(10'd555, 10'd321, 1'b1);
        a2       = 10'd300;
        b2       = 10'd9;
        bus.in_A = a2;
        bus.in_B = b2;
        @(posedge clk);
        #1;
        check_eq("restart_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        finish_op(a2, b2, 1'b1);

        // Random operations, occasionally with a zero operand
        for (int i = 0; i < 25; i++) begin
            a2 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            b2 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(a2, b2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
